// File: rtl/uart_transmitter.sv
// Free-running 8N1 UART transmitter with an exported baud tick.
// Ports: clk, rst (async, active high), bus[7:0] byte source, baud tick out, tx serial out.
module uart_transmitter #(
  parameter int CLK_FREQ  = 100000000,
  parameter int BAUD_RATE = 38400,
  parameter int DIVISOR   = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst,
  output logic       baud,
  input  logic [7:0] bus,
  output logic       tx
);

  localparam int            CW   = $clog2(DIVISOR);
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          tick;

  assign tick  = (cnt_q == LAST);
  assign cnt_d = tick ? '0 : cnt_q + CW'(1);
  assign baud  = tick;
  assign tx    = tx_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          shift_d = bus;
          state_d = START;
        end
        START: begin
          idx_d   = 3'd0;
          state_d = DATA;
        end
        DATA: begin
          if (idx_q == 3'd7) state_d = STOP;
          else               idx_d   = idx_q + 3'd1;
        end
        STOP: begin
          shift_d = bus;
          state_d = START;
        end
      endcase
    end
  end

  // tx is driven from the next state so the line moves on the
  // same edge that registers the tick.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_d)
      IDLE:  tx_d = 1'b1;
      START: tx_d = 1'b0;
      DATA:  tx_d = shift_d[idx_d];
      STOP:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= IDLE;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      tx_q    <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: bit-time waveform model plus a
// sampling UART receiver compared against the bytes driven.
module tb_uart_transmitter;

  localparam int CLK_FREQ  = 160;
  localparam int BAUD_RATE = 10;
  localparam int D         = CLK_FREQ / BAUD_RATE;
  localparam int R         = 8;

  logic       clk;
  logic       rst;
  logic       baud;
  logic [7:0] bus;
  logic       tx;

  int total = 0;
  int fails = 0;
  int edges = 0;
  int frame_err = 0;
  bit rx_en = 1'b0;
  bit rx_abort = 1'b0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_v;

  uart_transmitter #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .baud(baud),
    .bus (bus),
    .tx  (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // posedges since the last reset release
  always @(posedge clk or posedge rst) begin
    if (rst) edges <= 0;
    else     edges <= edges + 1;
  end

  always @(posedge rst) rx_abort = 1'b1;

  // receiver: samples mid-bit on falling clock edges
  initial begin : rx_model
    logic [7:0] b;
    bit ok;
    b = 8'h00;
    forever begin
      @(negedge clk);
      if (rx_en && !rst && tx === 1'b0) begin
        rx_abort = 1'b0;
        ok = 1'b1;
        repeat (D / 2) @(negedge clk);
        if (tx !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (D) @(negedge clk);
          b[i] = tx;
        end
        repeat (D) @(negedge clk);
        if (tx !== 1'b1) ok = 1'b0;
        if (!rx_abort) begin
          rx_q.push_back(b);
          if (!ok) frame_err++;
        end
      end
    end
  end

  // edge at which frame f latches bus and starts its start bit
  function automatic int ef(input int f);
    return D + 10 * D * f;
  endfunction

  task automatic wait_edge(input int n);
    while (edges < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus = 8'h00;
    rst = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1) begin
        fails++;
        $display("FAIL reset_tx got=%b exp=1", tx);
      end
      total++;
      if (baud !== 1'b0) begin
        fails++;
        $display("FAIL reset_baud got=%b exp=0", baud);
      end
    end
  endtask

  task automatic test_baud_and_single_frame();
    logic [7:0] h;
    int b;
    logic etx, eb;
    h = 8'h48;
    bus = h;
    @(negedge clk);
    rst = 1'b0;
    rx_en = 1'b1;
    exp_q.push_back(h);
    exp_q.push_back(h);
    for (int k = 1; k <= 11 * D; k++) begin
      #1;
      eb = (k % D == 0);
      b = (k - 1) / D;
      if (b == 0 || b == 10) etx = 1'b1;
      else if (b == 1)       etx = 1'b0;
      else                   etx = h[b-2];
      total++;
      if (baud !== eb) begin
        fails++;
        $display("FAIL baud_tick cyc=%0d got=%b exp=%b", k, baud, eb);
      end
      total++;
      if (tx !== etx) begin
        fails++;
        $display("FAIL frame_H cyc=%0d got=%b exp=%b", k, tx, etx);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] s[13];
    s = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
          8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};
    for (int i = 0; i < 13; i++) begin
      wait_edge(ef(1 + i) + 3 * D + 2);
      bus = s[i];
      exp_q.push_back(s[i]);
    end
    wait_edge(ef(15) + D);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL b2b_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL b2b_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
    total++;
    if (frame_err != 0) begin
      fails++;
      $display("FAIL b2b_framing got=%0d exp=0", frame_err);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_mid_frame_change();
    exp_q.push_back(8'h21);
    wait_edge(ef(15) + 3 * D + 2);
    bus = 8'hA5;
    exp_q.push_back(8'hA5);
    wait_edge(ef(16) + 4 * D + D / 2);
    bus = 8'h3C;
    exp_q.push_back(8'h3C);
    wait_edge(ef(18) + D);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL mid_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL mid_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
    total++;
    if (frame_err != 0) begin
      fails++;
      $display("FAIL mid_framing got=%0d exp=0", frame_err);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  // bytes change either mid data bits of the previous frame or in
  // the very cycle of the latching tick
  task automatic test_random_frames();
    logic [7:0] v;
    exp_q.push_back(8'h3C);
    last_v = 8'h3C;
    for (int k = 0; k < R; k++) begin
      v = 8'($urandom);
      if ($urandom_range(0, 1) == 1)
        wait_edge(ef(19 + k) - 1);
      else
        wait_edge(ef(18 + k) + D + $urandom_range(1, 8 * D - 1));
      bus = v;
      exp_q.push_back(v);
      last_v = v;
    end
    wait_edge(ef(19 + R) + D);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL rand_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rand_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
    total++;
    if (frame_err != 0) begin
      fails++;
      $display("FAIL rand_framing got=%0d exp=0", frame_err);
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] vr, v2;
    logic etx;
    vr = 8'($urandom) & 8'hEF;
    v2 = 8'($urandom);
    exp_q.push_back(last_v);
    wait_edge(ef(20 + R) - 1);
    bus = vr;
    wait_edge(ef(20 + R) + 5 * D + D / 2);
    total++;
    if (tx !== 1'b0) begin
      fails++;
      $display("FAIL pre_rst_bit4 got=%b exp=0", tx);
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1) begin
      fails++;
      $display("FAIL async_rst_tx got=%b exp=1", tx);
    end
    total++;
    if (baud !== 1'b0) begin
      fails++;
      $display("FAIL async_rst_baud got=%b exp=0", baud);
    end
    bus = v2;
    exp_q.push_back(v2);
    repeat (8 * D) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 2 * D; k++) begin
      #1;
      etx = (k <= D);
      total++;
      if (tx !== etx) begin
        fails++;
        $display("FAIL restart cyc=%0d got=%b exp=%b", k, tx, etx);
      end
      @(negedge clk);
    end
    wait_edge(ef(1) + D);
    total++;
    if (rx_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL rst_count got=%0d exp=%0d", rx_q.size(), exp_q.size());
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      total++;
      if (rx_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL rst_byte%0d got=%h exp=%h", i, rx_q[i], exp_q[i]);
      end
    end
    total++;
    if (frame_err != 0) begin
      fails++;
      $display("FAIL rst_framing got=%0d exp=0", frame_err);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    bus = 8'h00;
    last_v = 8'h00;
    #3;
    test_reset();
    test_baud_and_single_frame();
    test_back_to_back();
    test_mid_frame_change();
    test_random_frames();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- Free-running 8N1 UART transmitter.
- Serialises the byte present on an 8-bit parallel bus onto a single TX line: one start bit, 8 data bits LSB first, one stop bit.
- No valid/ready handshake. Once reset is released, the block transmits frames back to back and re-samples the bus at the start of every frame.
- Sits between a byte source (register or memory) and the board-level TX pin. Also exports its internal baud tick for other logic.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD_RATE, 38400, serial bit rate in bits/s.
- DIVISOR, CLK_FREQ/BAUD_RATE (2604 at defaults), clock cycles per bit. Integer division, truncated.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- baud  output  1  baud tick: one-clk-wide high pulse once every DIVISOR cycles.
- bus  input  8  byte to transmit. Sampled only at frame start.
- tx  output  1  serial line, idle high, registered.

Behaviour:
Interface:
- One clock (clk).
- Reset rst is asynchronous and active-high.
- All state is cleared immediately on rst=1, independent of clk.

Reset values:
- tx=1, baud=0, divider count=0, state=IDLE, bit index=0, shift register=0x00.

Baud divider:
- Counter runs 0..DIVISOR-1 continuously whenever rst=0.
- baud=1 for exactly the one cycle in which the count equals DIVISOR-1; the counter then wraps to 0.
- Tick period is exactly DIVISOR cycles. The first tick occurs DIVISOR cycles after reset deassertion.

State machine (IDLE, START, DATA, STOP):
- Advances only in cycles where baud=1.
- IDLE: tx=1.
  - On tick: latch bus into the shift register and go to START.
- START: tx=0.
  - On tick: bit index=0, go to DATA.
- DATA: tx=shift[index].
  - On tick with index<7: index+1.
  - On tick with index=7: go to STOP.
- STOP: tx=1.
  - On tick: latch bus and go to START. Frames are back to back with no idle gap.

Timing:
- tx is registered. It changes on the clock edge at which the tick is registered, so each bit is held exactly DIVISOR cycles.
- One frame is 10*DIVISOR cycles: 26040 cycles, or 260.4 us at defaults.

Boundary conditions:
- Changes on bus mid-frame do not affect the frame in progress. The new value is sent in the next frame.
- If bus changes in the same cycle as the latching tick, the value present at that clock edge is taken.
- rst asserted mid-frame: tx goes to 1 immediately and the frame is abandoned; no partial stop bit is required.
- After reset release the sequence restarts from IDLE: one idle bit time, then a START.
- DIVISOR must be at least 2. The counter width is sized to hold DIVISOR-1.

Test Plan:
- Reset check: hold rst=1 for 1000 cycles with bus=0x00 -> tx=1 and baud=0 throughout, including while clk toggles.
- Baud tick: release reset -> baud pulses high for 1 cycle. The first pulse comes 2604 cycles after release, then every 2604 cycles, with no extra pulses.
- Single frame: bus=0x48 ('H') before the first tick -> tx sequence, each bit held 2604 cycles: 0 (start), 0,0,0,1,0,0,1,0 (LSB first), 1 (stop).
- Back-to-back string: drive "Hello, World!" (0x48 0x65 0x6C 0x6C 0x6F 0x2C 0x20 0x57 0x6F 0x72 0x6C 0x64 0x21), changing bus once per 26040-cycle frame during the data bits -> a bench UART receiver decodes the same 13 bytes in order, with no framing errors and stop bits always 1.
- Mid-frame bus change: bus=0xA5 latched, change bus to 0x3C during data bit 3 -> the current frame still carries 0xA5 and the next frame carries 0x3C.
- Reset mid-frame: assert rst asynchronously (not on a clock edge) during data bit 4 -> tx=1 within the same time step. After release, one idle bit time, then the start bit of a fresh frame.
